// File: rtl/avalon_copy_master.sv
// avalon_copy_master: Avalon-MM word copier, pipelined reads buffered in a show-ahead FIFO.
// Define COPY_CHECKSUM_EN to accumulate a 32-bit sum of the written words.
`timescale 1ns/1ps
module avalon_copy_master #(
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 9,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic [31:0]       checksum,
    output logic [ADDR_W-1:0] rd_address,
    output logic              rd_read,
    input  logic              rd_waitrequest,
    input  logic [DATA_W-1:0] rd_readdata,
    input  logic              rd_readdatavalid,
    output logic [ADDR_W-1:0] wr_address,
    output logic              wr_write,
    output logic [DATA_W-1:0] wr_writedata,
    input  logic              wr_waitrequest
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state, state_n;
    logic [LEN_W-1:0]  rd_left, wr_left;
    logic [CW-1:0]     outst, count;
    logic [AW-1:0]     wptr, rptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              start_ok, rd_acc, wr_acc, push, last_wr;
    logic              done_q;

    always_comb begin
        start_ok = (state == IDLE) && start;
        // credit: words in flight plus words buffered never exceed the FIFO
        rd_read  = (state == RUN) && (rd_left != '0) &&
                   (({1'b0, outst} + {1'b0, count}) < (CW+1)'(FIFO_DEPTH));
        rd_acc   = rd_read && !rd_waitrequest;
        push     = rd_readdatavalid && (outst != '0);
        wr_write = (state == RUN) && (count != '0);
        wr_acc   = wr_write && !wr_waitrequest;
        last_wr  = wr_acc && (wr_left == LEN_W'(1));
        wr_writedata = (count != '0) ? mem[rptr] : '0;
        busy     = (state == RUN);
        done     = done_q;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: if (start) state_n = (len == '0) ? DONE : RUN;
            RUN:  if ((wr_left == '0) || last_wr) state_n = DONE;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            done_q     <= 1'b0;
            rd_address <= '0;
            wr_address <= '0;
            rd_left    <= '0;
            wr_left    <= '0;
            outst      <= '0;
            count      <= '0;
            wptr       <= '0;
            rptr       <= '0;
        end else begin
            state  <= state_n;
            // a zero-length copy reports one cycle later, from DONE
            done_q <= ((state == RUN) && last_wr) ||
                      ((state == DONE) && !done_q);
            if (start_ok) begin
                rd_address <= src_addr;
                wr_address <= dst_addr;
                rd_left    <= len;
                wr_left    <= len;
            end
            if (rd_acc) begin
                rd_address <= rd_address + ADDR_W'(1);
                rd_left    <= rd_left - LEN_W'(1);
            end
            unique case ({rd_acc, push})
                2'b10:   outst <= outst + CW'(1);
                2'b01:   outst <= outst - CW'(1);
                default: ;
            endcase
            if (push) wptr <= wptr + AW'(1);
            if (wr_acc) begin
                rptr       <= rptr + AW'(1);
                wr_address <= wr_address + ADDR_W'(1);
                wr_left    <= wr_left - LEN_W'(1);
            end
            unique case ({push, wr_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= rd_readdata;
    end

`ifdef COPY_CHECKSUM_EN
    localparam int SW = (DATA_W < 32) ? DATA_W : 32;

    logic [31:0] sum_q, word32;

    always_comb word32 = 32'(wr_writedata[SW-1:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (start_ok) begin
            sum_q <= '0;
        end else if (wr_acc) begin
            sum_q <= sum_q + word32;
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_avalon_copy_master.sv
// tb_avalon_copy_master: table vectors, corner sequences and random copies
// against a word-list model of the copy; Avalon slaves modelled with queues.
`timescale 1ns/1ps
module tb_avalon_copy_master;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 9;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] src_addr, dst_addr;
    logic [LEN_W-1:0]  len;
    logic              busy, done;
    logic [31:0]       checksum;
    logic [ADDR_W-1:0] rd_address, wr_address;
    logic              rd_read, rd_waitrequest, rd_readdatavalid;
    logic [DATA_W-1:0] rd_readdata, wr_writedata;
    logic              wr_write, wr_waitrequest;

    always #5 clk = ~clk;

    avalon_copy_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .FIFO_DEPTH(8)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .checksum(checksum),
        .rd_address(rd_address), .rd_read(rd_read),
        .rd_waitrequest(rd_waitrequest), .rd_readdata(rd_readdata),
        .rd_readdatavalid(rd_readdatavalid),
        .wr_address(wr_address), .wr_write(wr_write),
        .wr_writedata(wr_writedata), .wr_waitrequest(wr_waitrequest)
    );

    typedef struct { logic [31:0] d; int due; } rsp_t;
    typedef struct {
        logic [7:0]  src;
        logic [7:0]  dst;
        logic [8:0]  n;
        int          lat;
        int          stall;
        bit          rnd;
        logic [31:0] sum;
    } vec_t;

    logic [31:0] mem [256];
    rsp_t        rq[$];
    logic [39:0] wlog[$];
    logic [7:0]  rdlog[$];
    int          edges, n_vec, n_bad;
    int          lat, wr_stall;
    bit          rnd;
    int          rd_acc_cnt, wr_acc_cnt, done_cnt, busy_hi;
    int          rdreq_seen, wrreq_seen;
    int          done_cyc, last_wr_cyc, first_rd_cyc;
    logic [7:0]  first_rd_addr;
    bit          rd_hold, wr_hold;
    logic [7:0]  hold_ra, hold_wa;
    logic [31:0] hold_wd;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    // one clock: observe at negedge+1, then update slaves after the posedge
    task automatic tick();
        bit          ra, wa;
        logic [7:0]  raddr, waddr;
        logic [31:0] wd;
        rsp_t        r;
        #1;
        if (rd_hold) begin
            check("rd_hold_read", rd_read, 1);
            check("rd_hold_addr", rd_address, hold_ra);
        end
        if (wr_hold) begin
            check("wr_hold_write", wr_write, 1);
            check("wr_hold_addr", wr_address, hold_wa);
            check("wr_hold_data", wr_writedata, hold_wd);
        end
        rd_hold = rd_read && rd_waitrequest;
        hold_ra = rd_address;
        wr_hold = wr_write && wr_waitrequest;
        hold_wa = wr_address;
        hold_wd = wr_writedata;
        ra = rd_read && !rd_waitrequest;
        raddr = rd_address;
        wa = wr_write && !wr_waitrequest;
        waddr = wr_address;
        wd = wr_writedata;
        if (rd_read) begin
            rdreq_seen++;
            if (first_rd_cyc < 0) begin
                first_rd_cyc = edges;
                first_rd_addr = rd_address;
            end
        end
        if (wr_write) wrreq_seen++;
        if (wa) last_wr_cyc = edges;
        if (done) begin
            done_cnt++;
            done_cyc = edges;
        end
        if (busy) busy_hi++;
        @(posedge clk);
        edges++;
        @(negedge clk);
        if (ra) begin
            r.d = mem[raddr];
            r.due = edges + lat;
            rq.push_back(r);
            rdlog.push_back(raddr);
            rd_acc_cnt++;
        end
        if (wa) begin
            mem[waddr] = wd;
            wlog.push_back({waddr, wd});
            wr_acc_cnt++;
        end
        if (rq.size() > 0 && rq[0].due <= edges + 1) begin
            rd_readdatavalid = 1'b1;
            rd_readdata = rq[0].d;
            void'(rq.pop_front());
        end else begin
            rd_readdatavalid = 1'b0;
            rd_readdata = $urandom;
        end
        if (wr_stall > 0) begin
            wr_waitrequest = 1'b1;
            wr_stall--;
        end else begin
            wr_waitrequest = rnd && ($urandom_range(0, 2) == 0);
        end
        rd_waitrequest = rnd && ($urandom_range(0, 2) == 0);
    endtask

    task automatic clear_stats();
        wlog.delete();
        rdlog.delete();
        rd_acc_cnt = 0;
        wr_acc_cnt = 0;
        done_cnt = 0;
        busy_hi = 0;
        rdreq_seen = 0;
        wrreq_seen = 0;
        done_cyc = -1;
        last_wr_cyc = -1;
        first_rd_cyc = -1;
    endtask

    task automatic launch(input logic [7:0] s, input logic [7:0] d,
                          input logic [8:0] n, output int sc);
        src_addr = s;
        dst_addr = d;
        len = n;
        start = 1'b1;
        sc = edges;
        tick();
        start = 1'b0;
    endtask

    task automatic reset_vals(input string nm);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
        check({nm, "_checksum"}, checksum, 0);
        check({nm, "_rd_read"}, rd_read, 0);
        check({nm, "_wr_write"}, wr_write, 0);
        check({nm, "_rd_address"}, rd_address, 0);
        check({nm, "_wr_address"}, wr_address, 0);
        check({nm, "_wr_writedata"}, wr_writedata, 0);
    endtask

    // model: word i is read from src+i and lands at dst+i, mod 256
    task automatic run_copy(input string nm, input vec_t v,
                            input bit use_sum, input bit restart);
        logic [39:0] exp[$];
        logic [7:0]  ea[$];
        logic [31:0] msum, esum;
        logic [7:0]  sa, da;
        int          sc;
        msum = 0;
        for (int i = 0; i < int'(v.n); i++) begin
            sa = v.src + 8'(i);
            da = v.dst + 8'(i);
            exp.push_back({da, mem[sa]});
            ea.push_back(sa);
            msum += mem[sa];
        end
`ifdef COPY_CHECKSUM_EN
        esum = use_sum ? v.sum : msum;
`else
        esum = 0;
`endif
        clear_stats();
        lat = v.lat;
        wr_stall = v.stall;
        rnd = v.rnd;
        launch(v.src, v.dst, v.n, sc);
        #1 check({nm, "_busy_rise"}, busy, 1);
        for (int c = 0; c < 4000 && done_cnt == 0; c++) begin
            start = restart && (c == 10);
            src_addr = 8'h00;
            len = 9'd3;
            tick();
            start = 1'b0;
            if (v.stall > 0 && edges == sc + 15) begin
                check({nm, "_reads_in_stall"}, rd_acc_cnt, 8);
                check({nm, "_writes_in_stall"}, wr_acc_cnt, 0);
            end
        end
        rnd = 0;
        repeat (4) tick();
        #1;
        check({nm, "_done_pulses"}, done_cnt, 1);
        check({nm, "_busy_low"}, busy, 0);
        check({nm, "_done_timing"}, done_cyc, last_wr_cyc + 1);
        check({nm, "_first_rd_cyc"}, first_rd_cyc, sc + 1);
        check({nm, "_first_rd_addr"}, first_rd_addr, v.src);
        check({nm, "_n_reads"}, rd_acc_cnt, v.n);
        check({nm, "_n_writes"}, wlog.size(), v.n);
        for (int i = 0; i < exp.size() && i < wlog.size() &&
                        i < rdlog.size(); i++)
            check({nm, "_word"}, {rdlog[i], wlog[i]}, {ea[i], exp[i]});
        check({nm, "_checksum"}, checksum, esum);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t tbl[5];
        vec_t v;
        int   sc;
        n_vec = 0;
        n_bad = 0;
        edges = 0;
        reset = 1'b1;
        start = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len = '0;
        rd_waitrequest = 1'b0;
        wr_waitrequest = 1'b0;
        rd_readdatavalid = 1'b0;
        rd_readdata = '0;
        lat = 1;
        wr_stall = 0;
        rnd = 0;
        rd_hold = 0;
        wr_hold = 0;
        clear_stats();
        for (int a = 0; a < 256; a++) mem[a] = 32'h1000 + 32'(a);
        for (int a = 0; a < 4; a++) mem[8'h10 + a] = 32'(a + 1);

        tbl[0] = '{8'h10, 8'h80, 9'd4,  1, 0,  1'b0, 32'd10};
        tbl[1] = '{8'hFE, 8'h40, 9'd4,  1, 0,  1'b0, 32'h41FE};
        tbl[2] = '{8'h20, 8'hA0, 9'd16, 1, 20, 1'b0, 32'h10278};
        tbl[3] = '{8'h00, 8'h60, 9'd8,  2, 0,  1'b1, 32'h801C};
        tbl[4] = '{8'hC0, 8'h10, 9'd5,  4, 0,  1'b0, 32'h53CA};

        repeat (2) @(negedge clk);
        #1 reset_vals("por");
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 5; k++)
            run_copy($sformatf("tbl%0d", k), tbl[k], 1'b1, 1'b0);

        clear_stats();
        lat = 1;
        launch(8'h33, 8'h77, 9'd0, sc);
        repeat (5) tick();
        check("len0_done_pulses", done_cnt, 1);
        check("len0_done_cyc", done_cyc, sc + 2);
        check("len0_rd_read", rdreq_seen, 0);
        check("len0_wr_write", wrreq_seen, 0);
        check("len0_busy", busy_hi, 0);
        check("len0_checksum", checksum, 0);

        clear_stats();
        lat = 1;
        launch(8'h50, 8'hD0, 9'd16, sc);
        repeat (5) tick();
        #1 reset = 1'b1;
        #1 reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        rq.delete();
        rd_hold = 0;
        wr_hold = 0;
        rd_readdatavalid = 1'b1;
        rd_readdata = 32'hDEADBEEF;
        tick();
        #1;
        check("midrst_stale_ignored", wr_write, 0);
        check("midrst_busy", busy, 0);
        v = '{8'h50, 8'hE8, 9'd2, 1, 0, 1'b0, 32'h0};
        run_copy("after_rst", v, 1'b0, 1'b0);

        for (int a = 0; a < 256; a++) mem[a] = $urandom;
        v.src = 8'($urandom);
        v.dst = v.src + 8'h80;
        v.n = 9'd100;
        v.lat = 3;
        v.stall = 0;
        v.rnd = 1'b1;
        run_copy("rand100", v, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            v.src = 8'($urandom);
            v.dst = v.src + 8'h80;
            v.n = 9'($urandom_range(1, 120));
            v.lat = $urandom_range(1, 4);
            run_copy($sformatf("rand%0d", k), v, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
